// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word, RAM status and arbiter state encodings.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam word_t ARB_ERR_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr_i wins.
module rr_pick #(
  parameter int CPUS  = 2,
  parameter int IDX_W = 1
) (
  input  logic [CPUS-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             valid_o
);

  int c;

  // Scan from the farthest candidate back to ptr_i so the nearest requester is assigned last.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    c       = 0;
    for (int k = CPUS - 1; k >= 0; k--) begin
      c = (int'(ptr_i) + k) % CPUS;
      if (req_i[c]) begin
        grant_o = IDX_W'(c);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multicore memory arbiter: serialises per-core I/D requests onto a single RAM port.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS*WORD_W-1:0] iaddr,
  output logic [CPUS*WORD_W-1:0] iload,
  output logic [CPUS-1:0]        iwait,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS*WORD_W-1:0] daddr,
  input  logic [CPUS*WORD_W-1:0] dstore,
  output logic [CPUS*WORD_W-1:0] dload,
  output logic [CPUS-1:0]        dwait,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic [1:0]             ramstate,
  output logic                   err
);

  localparam int IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1;

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               is_d_q, is_d_d;
  logic               wr_q, wr_d;
  logic [WORD_W-1:0]  addr_q, addr_d;
  logic [WORD_W-1:0]  store_q, store_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic               err_q, err_d;

  logic [CPUS-1:0]    any_req;
  logic [IDX_W-1:0]   grant;
  logic               grant_valid;
  logic               live;
  logic               done;
  logic [WORD_W-1:0]  resp_word;
  ramstate_t          rs;

  assign any_req = iREN | dREN | dWEN;
  assign rs      = ramstate_t'(ramstate);

  rr_pick #(
    .CPUS  (CPUS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i   (any_req),
    .ptr_i   (rr_q),
    .grant_o (grant),
    .valid_o (grant_valid)
  );

  // The latched request stays valid only while its own enable is still asserted.
  assign live = is_d_q ? (wr_q ? dWEN[idx_q] : dREN[idx_q]) : iREN[idx_q];
  assign done = (state_q == XFER) && live && (rs == ACCESS || rs == ERROR);
  assign resp_word = (rs == ERROR) ? WORD_W'(ARB_ERR_WORD)
                   : (wr_q ? '0 : ramload);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    is_d_d  = is_d_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    store_d = store_q;
    rr_d    = rr_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = XFER;
          idx_d   = grant;
          is_d_d  = dREN[grant] | dWEN[grant];
          wr_d    = dWEN[grant];
          addr_d  = (dREN[grant] | dWEN[grant]) ? daddr[grant*WORD_W +: WORD_W]
                                                : iaddr[grant*WORD_W +: WORD_W];
          store_d = (dREN[grant] | dWEN[grant]) ? dstore[grant*WORD_W +: WORD_W] : '0;
        end
      end
      XFER: begin
        if (!live) begin
          state_d = IDLE;
        end else if (done) begin
          state_d = IDLE;
          rr_d    = (int'(idx_q) == CPUS - 1) ? '0 : idx_q + 1'b1;
          if (rs == ERROR) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      is_d_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      is_d_q  <= is_d_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  assign ramREN   = (state_q == XFER) && !wr_q;
  assign ramWEN   = (state_q == XFER) && wr_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign err      = err_q;

  always_comb begin
    iwait = '1;
    dwait = '1;
    iload = '0;
    dload = '0;
    if (done) begin
      if (is_d_q) begin
        dwait[idx_q] = 1'b0;
        dload[idx_q*WORD_W +: WORD_W] = resp_word;
      end else begin
        iwait[idx_q] = 1'b0;
        iload[idx_q*WORD_W +: WORD_W] = resp_word;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int CPUS = 2;
  localparam int W    = 32;

  logic            CLK = 1'b0;
  logic            nRST;
  logic [CPUS-1:0] iREN, dREN, dWEN;
  logic [CPUS*W-1:0] iaddr, daddr, dstore, iload, dload;
  logic [CPUS-1:0] iwait, dwait;
  logic            ramREN, ramWEN, err;
  logic [W-1:0]    ramaddr, ramstore, ramload;
  logic [1:0]      ramstate;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one outstanding transaction plus fairness pointer and sticky error.
  bit        m_busy;
  int        m_core;
  bit        m_isd, m_wr;
  logic [W-1:0] m_addr, m_store;
  int        m_rr;
  bit        m_err;

  always #5 CLK = ~CLK;

  mem_arbiter #(.CPUS(CPUS), .WORD_W(W)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_core = 0; m_isd = 0; m_wr = 0;
    m_addr = '0; m_store = '0; m_rr = 0; m_err = 0;
  endtask

  function automatic bit model_live();
    if (!m_busy) return 0;
    if (m_isd) return m_wr ? dWEN[m_core] : dREN[m_core];
    return iREN[m_core];
  endfunction

  // Compare every DUT output with the model for the current (pre-edge) inputs.
  task automatic check_outputs();
    logic [CPUS-1:0] e_iw, e_dw;
    logic [CPUS*W-1:0] e_il, e_dl;
    logic [W-1:0] r;
    bit done;
    e_iw = '1; e_dw = '1; e_il = '0; e_dl = '0;
    done = model_live() && (ramstate == 2'd2 || ramstate == 2'd3);
    if (done) begin
      r = (ramstate == 2'd3) ? 32'hBAD1BAD1 : (m_wr ? '0 : ramload);
      if (m_isd) begin e_dw[m_core] = 1'b0; e_dl[m_core*W +: W] = r; end
      else       begin e_iw[m_core] = 1'b0; e_il[m_core*W +: W] = r; end
      $display("xfer core=%0d kind=%s wr=%0d addr=%0h data=%0h st=%0d",
               m_core, m_isd ? "D" : "I", m_wr, m_addr, m_wr ? m_store : r, ramstate);
    end
    check("ramREN",   ramREN,   m_busy && !m_wr);
    check("ramWEN",   ramWEN,   m_busy && m_wr);
    check("ramaddr",  ramaddr,  m_addr);
    check("ramstore", ramstore, m_store);
    check("iwait",    iwait,    e_iw);
    check("dwait",    dwait,    e_dw);
    check("iload",    iload,    e_il);
    check("dload",    dload,    e_dl);
    check("err",      err,      m_err);
  endtask

  task automatic model_edge();
    bit live;
    int c;
    live = model_live();
    if (!m_busy) begin
      for (int k = 0; k < CPUS; k++) begin
        c = (m_rr + k) % CPUS;
        if (iREN[c] || dREN[c] || dWEN[c]) begin
          m_busy  = 1; m_core = c;
          m_isd   = dREN[c] || dWEN[c];
          m_wr    = dWEN[c];
          m_addr  = m_isd ? daddr[c*W +: W] : iaddr[c*W +: W];
          m_store = m_isd ? dstore[c*W +: W] : '0;
          break;
        end
      end
    end else if (!live) begin
      m_busy = 0;
    end else if (ramstate == 2'd2 || ramstate == 2'd3) begin
      m_busy = 0;
      m_rr   = (m_core + 1) % CPUS;
      if (ramstate == 2'd3) m_err = 1;
    end
  endtask

  // Inputs are set at the falling edge; check, take the rising edge, return at the next fall.
  task automatic step();
    #1;
    check_outputs();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic set_core(input int k, input bit ir, input logic [W-1:0] ia,
                          input bit dr, input bit dw, input logic [W-1:0] da,
                          input logic [W-1:0] ds);
    iREN[k] = ir; iaddr[k*W +: W] = ia;
    dREN[k] = dr; dWEN[k] = dw; daddr[k*W +: W] = da; dstore[k*W +: W] = ds;
  endtask

  initial begin
    nRST = 1'b0;
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = 2'd0;
    model_reset();
    repeat (2) @(negedge CLK);
    check("rst_ramREN", ramREN, 1'b0);
    check("rst_iwait",  iwait,  2'b11);
    check("rst_dwait",  dwait,  2'b11);
    check("rst_err",    err,    1'b0);
    nRST = 1'b1;

    // Instruction fetch with two BUSY cycles before ACCESS.
    set_core(0, 1, 32'h40, 0, 0, 0, 0);
    ramstate = 2'd1;
    step(); step(); step();
    ramstate = 2'd2; ramload = 32'hDEADBEEF;
    #1;
    check("t1_iload", iload[W-1:0], 32'hDEADBEEF);
    step();
    set_core(0, 0, 0, 0, 0, 0, 0);
    step();

    // Write beats read beats fetch within core 0.
    set_core(0, 1, 32'h44, 1, 1, 32'h80, 32'h1234);
    step();
    #1;
    check("t2_ramWEN",   ramWEN,   1'b1);
    check("t2_ramstore", ramstore, 32'h1234);
    step();
    set_core(0, 1, 32'h44, 0, 0, 0, 0);
    step(); step();
    set_core(0, 0, 0, 0, 0, 0, 0);

    // Both cores fetching continuously.
    set_core(0, 1, 32'h100, 0, 0, 0, 0);
    set_core(1, 1, 32'h104, 0, 0, 0, 0);
    repeat (8) begin ramload = $urandom; step(); end
    set_core(0, 0, 0, 0, 0, 0, 0);
    set_core(1, 0, 0, 0, 0, 0, 0);
    step();

    // ERROR completion for core 1 data read, then good transfers.
    set_core(1, 0, 0, 1, 0, 32'h200, 0);
    step();
    ramstate = 2'd3;
    step();
    ramstate = 2'd2;
    set_core(1, 1, 32'h300, 0, 0, 0, 0);
    repeat (4) step();
    check("t4_err_sticky", err, 1'b1);
    set_core(1, 0, 0, 0, 0, 0, 0);
    step();

    // Core 1 drops its read while RAM is busy.
    set_core(1, 0, 0, 1, 0, 32'h208, 0);
    ramstate = 2'd1;
    step(); step();
    dREN[1] = 1'b0;
    step(); step();

    // Reset in the middle of a transfer.
    set_core(0, 1, 32'h500, 0, 0, 0, 0);
    step();
    nRST = 1'b0;
    #1;
    model_reset();
    check("t6_ramREN", ramREN, 1'b0);
    check("t6_iwait",  iwait,  2'b11);
    check("t6_err",    err,    1'b0);
    check("t6_addr",   ramaddr, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    ramstate = 2'd2;
    step(); step(); step();

    // Random traffic with mostly-sticky requests.
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < CPUS; k++) begin
        if ($urandom_range(5) == 0) iREN[k] = ~iREN[k];
        if ($urandom_range(5) == 0) dREN[k] = ~dREN[k];
        if ($urandom_range(7) == 0) dWEN[k] = ~dWEN[k];
        iaddr[k*W +: W]  = $urandom;
        daddr[k*W +: W]  = $urandom;
        dstore[k*W +: W] = $urandom;
      end
      ramload  = $urandom;
      ramstate = ($urandom_range(15) == 0) ? 2'd3 : 2'($urandom_range(2));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
